// File: rtl/spi_master_dx.sv
// Full-duplex SPI master, all four CPOL/CPHA modes, one-of-CS_NUM active-low selects.
// One DATA_WIDTH-bit word is shifted out MSB first while a word is captured from MISO.
module spi_master_dx #(
  parameter int DATA_WIDTH = 8,
  parameter int CS_NUM     = 1,
  parameter int CLK_DIV    = 3,
  localparam int SEL_W     = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      cs_sel_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  wre_i,
  output logic                  rdy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic                  sclk_o,
  output logic [CS_NUM-1:0]     cs_no
);

  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int LAST_EDGE = 2 * DATA_WIDTH;
  localparam int EDGE_W    = $clog2(LAST_EDGE + 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CS_NUM-1:0]     cs_q, cs_d;
  logic                  cpha_q, cpha_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;
  logic                  rdy_q, rdy_d;

  logic [CS_NUM-1:0]     cs_hit;
  logic                  tick;
  logic [EDGE_W-1:0]     edge_k;

  // An out-of-range select matches no bit, so every chip select stays high.
  for (genvar gi = 0; gi < CS_NUM; gi++) begin : g_cs_dec
    assign cs_hit[gi] = (cs_sel_i == SEL_W'(gi));
  end

  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign edge_k = edge_cnt_q + EDGE_W'(1);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_d     = data_q;
    cs_d       = cs_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = cpol_i;
        div_d  = '0;
        if (wre_i) begin
          tx_d       = data_i;
          rx_d       = '0;
          cpha_d     = cpha_i;
          edge_cnt_d = '0;
          cs_d       = ~cs_hit;
          if (!cpha_i) mosi_d = data_i[DATA_WIDTH-1];
          state_d    = LEAD;
        end
      end
      // The terminal tick of LEAD is itself SCLK edge 1.
      LEAD, XFER: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          edge_cnt_d = edge_k;
          sclk_d     = ~sclk_q;
          if (!cpha_q) begin
            if (edge_k[0]) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], miso_i};
            end else if (edge_k != EDGE_W'(LAST_EDGE)) begin
              tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
              mosi_d = tx_q[DATA_WIDTH-2];
            end
          end else begin
            if (!edge_k[0]) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], miso_i};
            end else if (edge_k == EDGE_W'(1)) begin
              mosi_d = tx_q[DATA_WIDTH-1];
            end else begin
              tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
              mosi_d = tx_q[DATA_WIDTH-2];
            end
          end
          state_d = (edge_k == EDGE_W'(LAST_EDGE)) ? TRAIL : XFER;
        end
      end
      TRAIL: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          cs_d    = '1;
          data_d  = rx_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      div_q      <= '0;
      edge_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_q     <= '0;
      cs_q       <= '1;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      cs_q       <= cs_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      rdy_q      <= rdy_d;
    end
  end

  assign rdy_o  = rdy_q;
  assign done_o = done_q;
  assign data_o = data_q;
  assign mosi_o = mosi_q;
  assign sclk_o = sclk_q;
  assign cs_no  = cs_q;

endmodule

// File: tb/tb_spi_master_dx.sv
// Scoreboard bench for spi_master_dx: transfers are queued when driven and
// checked (data, timing, MOSI bits, chip selects) when done_o pulses.
`timescale 1ns/1ps
module tb_spi_master_dx;

  localparam int DW = 8;
  localparam int CSN = 5;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] slave;
    logic [2:0] sel;
    logic       cpol;
    logic       cpha;
    logic       loopb;
    logic       b2b;
  } item_t;

  logic           clk;
  logic           arst_ni;
  logic [DW-1:0]  data_i;
  logic [2:0]     cs_sel_i;
  logic           cpol_i, cpha_i, wre_i;
  logic           rdy_o, done_o;
  logic [DW-1:0]  data_o;
  logic           miso_i, mosi_o, sclk_o;
  logic [CSN-1:0] cs_no;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  item_t sb[$];
  item_t cur;
  int k, e0, edge_err, cs_err, sidx, last_done, done_cnt;
  logic [7:0] mosi_cap, slave_word;
  logic       miso_loop;
  logic       slave_bit;
  logic [CSN-1:0] exp_cs;
  bit   active, prev_rdy;
  logic prev_sclk;

  spi_master_dx #(.DATA_WIDTH(DW), .CS_NUM(CSN), .CLK_DIV(3)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .data_i(data_i), .cs_sel_i(cs_sel_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .wre_i(wre_i), .rdy_o(rdy_o),
    .done_o(done_o), .data_o(data_o), .miso_i(miso_i), .mosi_o(mosi_o),
    .sclk_o(sclk_o), .cs_no(cs_no)
  );

  assign slave_bit = (sidx < 8) ? slave_word[7 - sidx] : 1'b0;
  assign miso_i    = miso_loop ? mosi_o : slave_bit;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Monitor: follows the transfer in flight, acts as SPI slave, compares at done_o.
  initial begin
    active = 0; prev_rdy = 1; prev_sclk = 0; done_cnt = 0; last_done = -10;
    k = 0; e0 = 0; edge_err = 0; cs_err = 0; sidx = 0;
    mosi_cap = '0; slave_word = '0; miso_loop = 1'b1; exp_cs = '1;
    forever begin
      @(negedge clk);
      if (!arst_ni) begin
        active = 0;
        prev_rdy = 1;
        prev_sclk = sclk_o;
      end else begin
        if (prev_rdy && !rdy_o) begin
          if (sb.size() == 0) begin
            check("accept_unexp", 32'd1, 32'd0);
          end else begin
            cur = sb[0];
            active = 1; e0 = cyc; k = 0; edge_err = 0; cs_err = 0;
            sidx = 0; mosi_cap = '0;
            miso_loop = cur.loopb; slave_word = cur.slave;
            exp_cs = (cur.sel < CSN) ? ~(CSN'(1) << cur.sel) : '1;
            check("sclk_idle", 32'(sclk_o), 32'(cur.cpol));
            if (cur.b2b) check("b2b_gap", e0, last_done + 1);
          end
        end
        if (active) begin
          if (sclk_o !== prev_sclk) begin
            k++;
            if (cyc != e0 + 3 * k) edge_err++;
            if (cur.cpha ? (k % 2 == 0) : (k % 2 == 1)) mosi_cap = {mosi_cap[6:0], mosi_o};
            if (cur.cpha ? (k % 2 == 1 && k > 1) : (k % 2 == 0)) sidx++;
          end
          if (!done_o && cs_no !== exp_cs) cs_err++;
        end
        if (done_o) begin
          done_cnt++;
          if (sb.size() == 0) begin
            check("done_unexp", 32'd1, 32'd0);
          end else begin
            cur = sb.pop_front();
            $display("xfer tx=%02h sel=%0d cpol=%0d cpha=%0d rx=%02h exp=%02h done@E0+%0d",
                     cur.tx, cur.sel, cur.cpol, cur.cpha, data_o, cur.exp_rx, cyc - e0);
            check("rx_data", 32'(data_o), 32'(cur.exp_rx));
            check("done_time", cyc - e0, 32'd51);
            check("edge_count", k, 32'd16);
            check("edge_timing_errs", edge_err, 32'd0);
            check("mosi_bits", 32'(mosi_cap), 32'(cur.tx));
            check("cs_during_errs", cs_err, 32'd0);
            check("cs_release", 32'(cs_no), 32'h1F);
            check("rdy_at_done", 32'(rdy_o), 32'd1);
            active = 0;
            last_done = cyc;
          end
        end
        prev_rdy = rdy_o;
        prev_sclk = sclk_o;
      end
    end
  end

  task automatic wait_rdy();
    int n = 0;
    while (!rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_o) check("rdy_timeout", 32'(rdy_o), 32'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("xfer_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic push_item(input logic [7:0] tx, input logic cpol, input logic cpha,
                           input logic [2:0] sel, input logic loopb,
                           input logic [7:0] slv, input logic b2b);
    item_t it;
    it.tx = tx; it.cpol = cpol; it.cpha = cpha; it.sel = sel; it.loopb = loopb;
    it.slave = slv; it.exp_rx = loopb ? tx : slv; it.b2b = b2b;
    sb.push_back(it);
  endtask

  task automatic do_xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                         input logic [2:0] sel, input logic loopb, input logic [7:0] slv);
    wait_rdy();
    @(negedge clk);
    cpol_i = cpol;
    @(negedge clk);
    push_item(tx, cpol, cpha, sel, loopb, slv, 1'b0);
    data_i = tx; cpha_i = cpha; cs_sel_i = sel; wre_i = 1'b1;
    @(posedge clk);
    #1 wre_i = 1'b0;
    wait_empty();
  endtask

  initial begin
    int n, dn_before;
    logic [7:0] rtx, rsl;
    logic [1:0] rmode;
    logic [2:0] rsel;
    arst_ni = 1'b1; data_i = '0; cs_sel_i = '0; cpol_i = 1'b0; cpha_i = 1'b0; wre_i = 1'b0;
    #1 arst_ni = 1'b0;
    #4;
    check("rst_cs", 32'(cs_no), 32'h1F);
    check("rst_sclk", 32'(sclk_o), 32'd0);
    check("rst_rdy", 32'(rdy_o), 32'd1);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_mosi", 32'(mosi_o), 32'd0);
    repeat (3) @(negedge clk);
    arst_ni = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_cs", 32'(cs_no), 32'h1F);
    check("idle_sclk", 32'(sclk_o), 32'd0);
    check("idle_rdy", 32'(rdy_o), 32'd1);

    do_xfer(8'hA5, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00);  // mode 0 loopback
    do_xfer(8'h5A, 1'b1, 1'b1, 3'd3, 1'b0, 8'h3C);  // mode 3, slave returns 0x3C
    do_xfer(8'hC3, 1'b0, 1'b1, 3'd4, 1'b0, 8'h96);  // mode 1
    do_xfer(8'h7E, 1'b1, 1'b0, 3'd2, 1'b0, 8'h81);  // mode 2, only cs_no[2]
    do_xfer(8'hE7, 1'b0, 1'b0, 3'd5, 1'b1, 8'h00);  // out-of-range select

    // Back-to-back with wre_i held high, then ignored pulses and a cpol glitch.
    wait_rdy();
    @(negedge clk);
    cpol_i = 1'b0;
    @(negedge clk);
    push_item(8'h12, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00, 1'b0);
    data_i = 8'h12; cpha_i = 1'b0; cs_sel_i = 3'd1; wre_i = 1'b1;
    @(posedge clk);
    #1;
    push_item(8'h34, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00, 1'b1);
    data_i = 8'h34;
    n = 0;
    @(negedge clk);
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 wre_i = 1'b0;
    repeat (10) @(negedge clk);
    data_i = 8'hFF; wre_i = 1'b1; cpol_i = 1'b1;
    @(negedge clk);
    wre_i = 1'b0;
    repeat (15) @(negedge clk);
    wre_i = 1'b1;
    @(negedge clk);
    wre_i = 1'b0; cpol_i = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);
    check("b2b_no_extra", 32'(rdy_o), 32'd1);

    // Reset around SCLK edge 7 of a transfer.
    wait_rdy();
    @(negedge clk);
    push_item(8'hFF, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    data_i = 8'hFF; cpha_i = 1'b0; cs_sel_i = 3'd0; wre_i = 1'b1;
    @(posedge clk);
    #1 wre_i = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    while (k < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    dn_before = done_cnt;
    arst_ni = 1'b0;
    #1;
    check("mid_rst_cs", 32'(cs_no), 32'h1F);
    check("mid_rst_sclk", 32'(sclk_o), 32'd0);
    check("mid_rst_mosi", 32'(mosi_o), 32'd0);
    check("mid_rst_rdy", 32'(rdy_o), 32'd1);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_data", 32'(data_o), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    arst_ni = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_rst_no_done", done_cnt, dn_before);
    do_xfer(8'h3C, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00);

    for (int i = 0; i < 4; i++) begin
      rtx = 8'($urandom);
      rsl = 8'($urandom);
      rmode = 2'($urandom_range(0, 3));
      rsel = 3'($urandom_range(0, 7));
      do_xfer(rtx, rmode[1], rmode[0], rsel, 1'b0, rsl);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
